ghost_sprite_render: RTL and testbench
======================================

# ghost_sprite_render

Pixel-side reader of ghost motion state. Takes a ghost's position/direction outputs plus the VGA scan coordinate. Produces a registered 12-bit RGB pixel and a coverage flag for a 16×16 animated ghost sprite. Sits between the ghost mover and the VGA colour mux, one instance per ghost.

## Interface
Parameters:
- BODY_COLOR, 12'h0FF — RGB444 body colour (cyan for ghost four).
- ANIM_FRAMES, 8 — frame_start pulses per skirt animation toggle; legal range 1–255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- ghost_x  in  10  ghost centre X.
- ghost_y  in  9  ghost centre Y.
- ghost_dir  in  2  facing: 00 up, 01 down, 10 left, 11 right.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  pix_x/pix_y are a visible pixel this cycle.
- pix_x  in  10  scan X.
- pix_y  in  9  scan Y.
- hit  out  1  sprite covers the delayed pixel.
- color  out  12  RGB444 for the delayed pixel; 0 when hit=0.
- color_valid  out  1  pix_valid delayed 2 cycles.

## Operation
- Shadow registers sx, sy, sdir load ghost_x, ghost_y, ghost_dir on frame_start. Reset values: 320, 240, 11. The sprite never tears mid-frame.
- Animation: 8-bit frame counter increments per frame_start. At ANIM_FRAMES-1 it wraps to 0 and toggles the 1-bit anim.
- Stage 1 (registered): col = pix_x − sx + 8 and row = pix_y − sy + 8, both computed in 11-bit signed. Set inbox when both fall in 0..15. There is no wrap: a ghost near 0 is clipped, not mirrored. Register col[3:0], row[3:0], inbox, and pix_valid.
- Stage 2 (registered) body mask:
  - row 0: cols 5–10.
  - row 1: cols 3–12.
  - rows 2–13: cols 1–14.
  - rows 14–15: cols 1–14, where ((col>>1)+anim) is even.
- Eyes: 4×4 white (12'hFFF) squares at rows 4–7, cols 2–5 and 9–12, using eye-local (er, ec). They override the body.
- Pupil: 2×2 at 12'h00F inside each eye, overriding white.
  - dir 00: er 0–1, ec 1–2.
  - dir 01: er 2–3, ec 1–2.
  - dir 10: er 1–2, ec 0–1.
  - dir 11: er 1–2, ec 2–3.
- hit = inbox & (body | eye). color = selected colour when hit, else 0.

## Timing
- Latency: 2 clk from pix_valid/pix_x/pix_y to hit/color/color_valid, fully pipelined (one pixel per clk).
- Outputs are registered. When color_valid=0, hit and color are 0.
- Reset values: hit=0, color=0, color_valid=0; pipeline valids, frame counter, and anim = 0; shadows = 320/240/11.
- Reset mid-frame: both pipeline stages are flushed. Outputs are 0 on the cycle after rst is sampled low, and stay 0 until 2 clk after the first pix_valid following release.
- frame_start and pix_valid in the same cycle: that pixel uses the old shadow values and the old anim. New values apply from the next cycle.
- frame_start while rst is low: ignored; reset wins.
- Changes to ghost_x/ghost_y/ghost_dir between frame_start pulses have no effect on output.

## Configuration
- GHOST_FRIGHT_EN defined: adds input fright (1 bit), latched with the shadows on frame_start (reset 0). While the latched fright=1:
  - body colour is 12'h00F;
  - eyes are not drawn;
  - eye-local er 1–2, ec 1–2 of each eye drawn in 12'hFC9;
  - the rest of each eye square is body colour.
- GHOST_FRIGHT_EN undefined: no fright port; behaviour exactly as in Operation.

## Test plan
- Reset, then frame_start with ghost (320,240,11). Pixel (320,240) -> 2 clk later hit=1, color=12'h0FF, color_valid=1.
- Same ghost, pixel (312,232), i.e. row 0 col 0 -> hit=0, color=0. Pixel (317,232), i.e. row 0 col 5 -> hit=1, color=12'h0FF.
- dir 11: pixel (316,237), i.e. row 5 col 4 -> color 12'h00F. Pixel (314,236), i.e. row 4 col 2 -> 12'hFFF. Change to dir 10 without frame_start -> unchanged. After frame_start, (316,237) -> 12'hFFF.
- Skirt: anim=0, row 14 -> col 1 hit=1, col 2 hit=0. After 8 frame_start pulses -> col 1 hit=0, col 2 hit=1.
- ghost_x=3, pixel (1020,240) -> hit=0 (no wrap). Pixel (0,240) -> hit=1. Assert rst for 1 clk mid-stream -> color_valid=0 for the next 2 pixel slots.
- GHOST_FRIGHT_EN: latched fright=1, (320,240) -> 12'h00F. (316,237) -> 12'hFC9. (314,236) -> 12'h00F.

Source files
------------

// File: rtl/ghost_sprite_render.sv
// Per-ghost 16x16 sprite renderer: frame-latched ghost state, two-stage pixel pipeline.
// Define GHOST_FRIGHT_EN to add the latched fright input (blue frightened ghost).
module ghost_sprite_render #(
    parameter logic [11:0] BODY_COLOR  = 12'h0FF,
    parameter int          ANIM_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  ghost_x,
    input  logic [8:0]  ghost_y,
    input  logic [1:0]  ghost_dir,
    input  logic        frame_start,
`ifdef GHOST_FRIGHT_EN
    input  logic        fright,
`endif
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    output logic        hit,
    output logic [11:0] color,
    output logic        color_valid
);

    localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

    logic [9:0]  sx;
    logic [8:0]  sy;
    logic [1:0]  sdir;
    logic        sfright;
    logic [7:0]  frame_cnt;
    logic        anim;

    // Shadows only move at frame_start so the sprite never tears mid-frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sx        <= 10'd320;
            sy        <= 9'd240;
            sdir      <= 2'b11;
            sfright   <= 1'b0;
            frame_cnt <= 8'd0;
            anim      <= 1'b0;
        end else if (frame_start) begin
            sx   <= ghost_x;
            sy   <= ghost_y;
            sdir <= ghost_dir;
`ifdef GHOST_FRIGHT_EN
            sfright <= fright;
`else
            sfright <= 1'b0;
`endif
            if (frame_cnt == ANIM_LAST) begin
                frame_cnt <= 8'd0;
                anim      <= ~anim;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    logic [10:0] col_w;
    logic [10:0] row_w;
    logic        inbox_w;

    assign col_w   = {1'b0, pix_x} - {1'b0, sx} + 11'd8;
    assign row_w   = {2'b00, pix_y} - {2'b00, sy} + 11'd8;
    assign inbox_w = (col_w[10:4] == 7'd0) && (row_w[10:4] == 7'd0);

    logic       v1;
    logic       inbox1;
    logic [3:0] col1;
    logic [3:0] row1;
    logic [1:0] dir1;
    logic       anim1;
    logic       fright1;

    // Direction/anim/fright travel with the pixel so a same-cycle frame_start
    // cannot leak new values into a pixel sampled with the old shadows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1      <= 1'b0;
            inbox1  <= 1'b0;
            col1    <= 4'd0;
            row1    <= 4'd0;
            dir1    <= 2'b11;
            anim1   <= 1'b0;
            fright1 <= 1'b0;
        end else begin
            v1      <= pix_valid;
            inbox1  <= inbox_w;
            col1    <= col_w[3:0];
            row1    <= row_w[3:0];
            dir1    <= sdir;
            anim1   <= anim;
            fright1 <= sfright;
        end
    end

    logic        body;
    logic        eye_rows;
    logic        eye_l;
    logic        eye_r;
    logic        eye;
    logic [1:0]  er;
    logic [1:0]  ec;
    logic        pupil;
    logic        inner;
    logic        hit_w;
    logic [11:0] pix_color;

    always_comb begin
        body      = 1'b0;
        pupil     = 1'b0;
        pix_color = BODY_COLOR;

        case (row1)
            4'd0:         body = (col1 >= 4'd5) && (col1 <= 4'd10);
            4'd1:         body = (col1 >= 4'd3) && (col1 <= 4'd12);
            4'd14, 4'd15: body = (col1 >= 4'd1) && (col1 <= 4'd14) && (col1[1] == anim1);
            default:      body = (col1 >= 4'd1) && (col1 <= 4'd14);
        endcase

        // Eye-local coordinates reduce to 2-bit arithmetic on the low bits.
        eye_rows = (row1 >= 4'd4) && (row1 <= 4'd7);
        eye_l    = eye_rows && (col1 >= 4'd2) && (col1 <= 4'd5);
        eye_r    = eye_rows && (col1 >= 4'd9) && (col1 <= 4'd12);
        eye      = eye_l || eye_r;
        er       = row1[1:0];
        ec       = eye_l ? (col1[1:0] - 2'd2) : (col1[1:0] - 2'd1);
        inner    = (er >= 2'd1) && (er <= 2'd2) && (ec >= 2'd1) && (ec <= 2'd2);

        case (dir1)
            2'b00:   pupil = (er <= 2'd1) && (ec >= 2'd1) && (ec <= 2'd2);
            2'b01:   pupil = (er >= 2'd2) && (ec >= 2'd1) && (ec <= 2'd2);
            2'b10:   pupil = (er >= 2'd1) && (er <= 2'd2) && (ec <= 2'd1);
            default: pupil = (er >= 2'd1) && (er <= 2'd2) && (ec >= 2'd2);
        endcase

        if (eye) begin
            pix_color = pupil ? 12'h00F : 12'hFFF;
        end

`ifdef GHOST_FRIGHT_EN
        if (fright1) begin
            pix_color = (eye && inner) ? 12'hFC9 : 12'h00F;
        end
`endif

        hit_w = inbox1 && (body || eye);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit         <= 1'b0;
            color       <= 12'h000;
            color_valid <= 1'b0;
        end else begin
            hit         <= v1 && hit_w;
            color       <= (v1 && hit_w) ? pix_color : 12'h000;
            color_valid <= v1;
        end
    end

endmodule

// File: tb/tb_ghost_sprite_render.sv
// Scoreboard bench for ghost_sprite_render: directed pixels push expectations, a monitor pops them.
// Fright vectors are included when GHOST_FRIGHT_EN is defined.
module tb_ghost_sprite_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ghost_x;
    logic [8:0]  ghost_y;
    logic [1:0]  ghost_dir;
    logic        frame_start;
`ifdef GHOST_FRIGHT_EN
    logic        fright;
`endif
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        hit;
    logic [11:0] color;
    logic        color_valid;

    int checks   = 0;
    int failures = 0;
    logic        mon_en = 1'b0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    ghost_sprite_render dut (
        .clk         (clk),
        .rst         (rst),
        .ghost_x     (ghost_x),
        .ghost_y     (ghost_y),
        .ghost_dir   (ghost_dir),
        .frame_start (frame_start),
`ifdef GHOST_FRIGHT_EN
        .fright      (fright),
`endif
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hit         (hit),
        .color       (color),
        .color_valid (color_valid)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (color_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got hit=%0b color=%h with nothing expected", hit, color);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    if ({hit, color} !== e) begin
                        failures++;
                        $display("FAIL pixel: got hit=%0b color=%h, expected hit=%0b color=%h",
                                 hit, color, e[12], e[11:0]);
                    end
                end
            end else begin
                checks++;
                if (hit !== 1'b0 || color !== 12'h000) begin
                    failures++;
                    $display("FAIL idle_zero: got hit=%0b color=%h, expected 0/000", hit, color);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic pix(input int x, input int y, input logic h, input logic [11:0] c);
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        pix_x       = 10'(x);
        pix_y       = 9'(y);
        exp_q.push_back({h, c});
    endtask

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic frame(input int x, input int y, input logic [1:0] d);
        @(negedge clk);
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        ghost_x     = 10'(x);
        ghost_y     = 9'(y);
        ghost_dir   = d;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d outputs still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst         = 1'b0;
        ghost_x     = 10'd0;
        ghost_y     = 9'd0;
        ghost_dir   = 2'b00;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = 10'd0;
        pix_y       = 9'd0;
`ifdef GHOST_FRIGHT_EN
        fright      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_color", 32'(color), 32'd0);
        check("reset_valid", 32'(color_valid), 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        // pulse 1, anim 0
        frame(320, 240, 2'b11);
        pix(320, 240, 1'b1, 12'h0FF);
        pix(312, 232, 1'b0, 12'h000);
        pix(317, 232, 1'b1, 12'h0FF);
        pix(322, 232, 1'b1, 12'h0FF);
        pix(323, 232, 1'b0, 12'h000);
        pix(314, 233, 1'b0, 12'h000);
        pix(315, 233, 1'b1, 12'h0FF);
        pix(316, 237, 1'b1, 12'h00F);
        pix(314, 236, 1'b1, 12'hFFF);
        pix(321, 237, 1'b1, 12'hFFF);
        pix(323, 237, 1'b1, 12'h00F);
        pix(327, 247, 1'b0, 12'h000);
        pix(313, 246, 1'b1, 12'h0FF);
        pix(314, 246, 1'b0, 12'h000);
        idle();
        drain();

        // direction change without frame_start is invisible
        @(negedge clk);
        ghost_dir = 2'b10;
        pix(316, 237, 1'b1, 12'h00F);
        idle();
        drain();

        // pulse 2: facing left
        frame(320, 240, 2'b10);
        pix(316, 237, 1'b1, 12'hFFF);
        pix(315, 237, 1'b1, 12'h00F);
        idle();

        // pulse 3 coincident with a pixel: that pixel still sees dir 10
        @(negedge clk);
        frame_start = 1'b1;
        ghost_x     = 10'd320;
        ghost_y     = 9'd240;
        ghost_dir   = 2'b01;
        pix_valid   = 1'b1;
        pix_x       = 10'd315;
        pix_y       = 9'd237;
        exp_q.push_back({1'b1, 12'h00F});
        pix(315, 237, 1'b1, 12'hFFF);
        pix(315, 239, 1'b1, 12'h00F);
        idle();
        drain();

        // pulses 4..7: anim still 0
        for (int i = 0; i < 4; i++) frame(320, 240, 2'b11);
        pix(313, 246, 1'b1, 12'h0FF);
        pix(314, 246, 1'b0, 12'h000);
        idle();
        // pulse 8 toggles anim
        frame(320, 240, 2'b11);
        pix(313, 246, 1'b0, 12'h000);
        pix(314, 246, 1'b1, 12'h0FF);
        pix(326, 246, 1'b1, 12'h0FF);
        idle();
        drain();

        // ghost near the left edge: clipped, not wrapped
        frame(3, 240, 2'b11);
        pix(1020, 240, 1'b0, 12'h000);
        pix(0, 240, 1'b1, 12'h0FF);
        pix(10, 240, 1'b0, 12'h000);
        idle();
        drain();

        // mid-stream reset with a coincident frame_start that must be ignored
        @(negedge clk);
        pix_valid = 1'b1;
        pix_x     = 10'd320;
        pix_y     = 9'd240;
        @(negedge clk);
        rst         = 1'b0;
        frame_start = 1'b1;
        ghost_x     = 10'd100;
        ghost_y     = 9'd100;
        ghost_dir   = 2'b00;
        @(negedge clk);
        rst         = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        check("flush_slot1_valid", 32'(color_valid), 32'd0);
        @(negedge clk);
        check("flush_slot2_valid", 32'(color_valid), 32'd0);
        @(negedge clk);
        check("flush_slot3_valid", 32'(color_valid), 32'd0);
        pix(320, 240, 1'b1, 12'h0FF);
        pix(313, 246, 1'b1, 12'h0FF);
        pix(314, 246, 1'b0, 12'h000);
        idle();
        drain();

`ifdef GHOST_FRIGHT_EN
        @(negedge clk);
        fright = 1'b1;
        frame(320, 240, 2'b11);
        fright = 1'b0;
        pix(320, 240, 1'b1, 12'h00F);
        pix(316, 237, 1'b1, 12'hFC9);
        pix(314, 236, 1'b1, 12'h00F);
        idle();
        drain();
        frame(320, 240, 2'b11);
        pix(316, 237, 1'b1, 12'h00F);
        idle();
        drain();
`endif

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
